// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg
//   Shared definitions for stream_mux_nt1 and its round-robin arbiter.
//   - MODE_FIXED / MODE_RR : encodings of the run-time selection mode input.
//   - onehot_to_idx        : converts a one-hot grant vector (up to 32 bits)
//                            into the index of its set bit.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // OR-ing the indices of all set bits gives the index of a one-hot vector
  // without a priority chain; an all-zero vector yields 0.
  function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin arbiter. Grants the first requesting
//   channel found when searching ptr, ptr+1, ... modulo N.
//   Ports:
//     req [N]  : per-channel request
//     ptr [SW] : highest-priority channel index (expected < N)
//     gnt [N]  : one-hot grant, all-zero when nothing requests
module rr_arbiter #(
  parameter int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [N-1:0]   gnt_rot;
  logic [2*N-1:0] gnt_dbl;
  logic           found;

  // Rotate requests so that channel 'ptr' lands at bit 0; the search then
  // becomes a simple fixed-priority scan from bit 0 upward.
  assign req_dbl = {req, req} >> ptr;
  assign req_rot = req_dbl[N-1:0];

  always_comb begin
    gnt_rot = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_rot[k]) begin
        gnt_rot[k] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // Rotate the grant back: the upper half of the doubled, left-shifted
  // vector holds the grant in original channel order.
  assign gnt_dbl = {gnt_rot, gnt_rot} << ptr;
  assign gnt     = gnt_dbl[2*N-1:N];

endmodule

// File: rtl/stream_mux_nt1.sv
// stream_mux_nt1
//   N-channel stream multiplexer with a single registered output stage and
//   valid/ready handshake. Mode 0 forwards the channel named by 'sel';
//   mode 1 arbitrates round-robin among valid channels.
//   Optional packet lock: define STREAM_MUX_PKT_LOCK_EN to add in_last/out_last
//   and hold round-robin arbitration on a channel until its last word.
//   Ports:
//     clk, rst_n          : clock (rising edge), async active-low reset
//     in_valid [N]        : per-channel valid
//     in_data  [N*W]      : channel i data at [i*W +: W]
//     in_last  [N]        : (STREAM_MUX_PKT_LOCK_EN) per-channel end of packet
//     in_ready [N]        : per-channel ready (combinational)
//     mode                : 0 = fixed select, 1 = round-robin
//     sel      [SW]       : channel index used in fixed mode
//     out_valid/out_data  : registered output word
//     out_chan [SW]       : channel that sourced out_data
//     out_last            : (STREAM_MUX_PKT_LOCK_EN) registered end of packet
//     out_ready           : downstream ready
module stream_mux_nt1
  import stream_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
`ifdef STREAM_MUX_PKT_LOCK_EN
  input  logic [N-1:0]    in_last,
  output logic            out_last,
`endif
  output logic [N-1:0]    in_ready,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_chan,
  input  logic            out_ready
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [SW-1:0] rr_ptr;
  logic          load;
  logic          sel_ok;
  logic [N-1:0]  fix_cand;
  logic [N-1:0]  rr_req;
  logic [N-1:0]  rr_gnt;
  logic [N-1:0]  cand;
  logic [N-1:0]  xfer_vec;
  logic          xfer;
  logic [SW-1:0] xfer_idx;
  logic [SW-1:0] ptr_next;
  logic [W-1:0]  xfer_data;

  assign load = !out_valid || out_ready;

  // Fixed mode: the candidate is 'sel' regardless of its valid, so its ready
  // tracks load; an out-of-range index selects nothing.
  assign sel_ok   = int'(sel) < N;
  assign fix_cand = sel_ok ? (ONE << sel) : '0;

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic          locked;
  logic [SW-1:0] lock_chan;
  logic          xfer_last;

  // While a packet is open only its channel may be granted, even if it
  // stalls and other channels are waiting.
  assign rr_req    = locked ? (in_valid & (ONE << lock_chan)) : in_valid;
  assign xfer_last = |(in_last & xfer_vec);
`else
  assign rr_req = in_valid;
`endif

  rr_arbiter #(.N(N)) u_arb (
    .req (rr_req),
    .ptr (rr_ptr),
    .gnt (rr_gnt)
  );

  assign cand     = (mode == MODE_RR) ? rr_gnt : fix_cand;
  // rst_n gates ready so no producer sees a handshake while reset is held.
  assign in_ready = cand & {N{load & rst_n}};
  assign xfer_vec = in_valid & in_ready;
  assign xfer     = |xfer_vec;
  assign xfer_idx = SW'(onehot_to_idx(32'(xfer_vec)));
  assign ptr_next = (xfer_idx == SW'(N - 1)) ? '0 : xfer_idx + SW'(1);

  always_comb begin
    xfer_data = '0;
    for (int i = 0; i < N; i++) begin
      if (xfer_vec[i]) xfer_data = xfer_data | in_data[i*W +: W];
    end
  end

  // Output stage: reload whenever empty or draining; data/chan only move on
  // a real transfer so an idle cycle keeps the last word visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
      out_last  <= 1'b0;
`endif
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= xfer_data;
        out_chan <= xfer_idx;
`ifdef STREAM_MUX_PKT_LOCK_EN
        out_last <= xfer_last;
`endif
      end
    end
  end

  // Round-robin pointer (and packet lock): only round-robin transfers move it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
      locked    <= 1'b0;
      lock_chan <= '0;
`endif
    end else if (xfer && (mode == MODE_RR)) begin
`ifdef STREAM_MUX_PKT_LOCK_EN
      if (xfer_last) begin
        rr_ptr <= ptr_next;
        locked <= 1'b0;
      end else begin
        locked    <= 1'b1;
        lock_chan <= xfer_idx;
      end
`else
      rr_ptr <= ptr_next;
`endif
    end
  end

endmodule

// File: tb/tb_stream_mux_nt1.sv
// tb_stream_mux_nt1
//   Directed, table-driven bench for stream_mux_nt1 (N=4, W=8). Each table row
//   is one clock: inputs, expected in_ready before the edge, expected output
//   register after the edge. Hand-written sequences cover async reset and,
//   with STREAM_MUX_PKT_LOCK_EN defined, packet lock.
module tb_stream_mux_nt1;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_ready;
  logic            mode;
  logic [SW-1:0]   sel;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_chan;
  logic            out_ready;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic [N-1:0]    in_last;
  logic            out_last;
`endif

  stream_mux_nt1 #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef STREAM_MUX_PKT_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          md;
    logic [1:0]    sl;
    logic [3:0]    vld;
    logic [31:0]   dat;
    logic          ordy;
    logic [3:0]    exp_rdy;
    logic          exp_ov;
    logic [7:0]    exp_od;
    logic [1:0]    exp_oc;
  } vec_t;

  localparam logic [31:0] D  = 32'h1312_1110;
  localparam logic [31:0] DA = 32'h13A5_1110;

  vec_t vecs[23];
  int   n_checks;
  int   n_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // fixed select (sel=2), then round-robin fairness, backpressure,
    // sparse wrap, mode change
    vecs[0]  = '{1'b0, 2'd2, 4'b0100, DA, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    vecs[1]  = '{1'b0, 2'd2, 4'b0000, DA, 1'b1, 4'b0100, 1'b0, 8'hA5, 2'd2};
    vecs[2]  = '{1'b1, 2'd0, 4'b1111, D,  1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[3]  = '{1'b1, 2'd0, 4'b1111, D,  1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    vecs[4]  = '{1'b1, 2'd0, 4'b1111, D,  1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    vecs[5]  = '{1'b1, 2'd0, 4'b1111, D,  1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    vecs[6]  = '{1'b1, 2'd0, 4'b1111, D,  1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[7]  = '{1'b1, 2'd0, 4'b1111, D,  1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    vecs[8]  = '{1'b1, 2'd0, 4'b1111, D,  1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    vecs[9]  = '{1'b1, 2'd0, 4'b1111, D,  1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    vecs[10] = '{1'b1, 2'd0, 4'b1111, D,  1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[11] = '{1'b1, 2'd0, 4'b1111, D,  1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    vecs[12] = '{1'b1, 2'd0, 4'b1111, D,  1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
    vecs[13] = '{1'b1, 2'd0, 4'b1111, D,  1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
    vecs[14] = '{1'b1, 2'd0, 4'b1111, D,  1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
    vecs[15] = '{1'b1, 2'd0, 4'b1111, D,  1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    vecs[16] = '{1'b1, 2'd0, 4'b0011, D,  1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[17] = '{1'b1, 2'd0, 4'b0011, D,  1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    vecs[18] = '{1'b1, 2'd0, 4'b0011, D,  1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[19] = '{1'b1, 2'd0, 4'b0000, D,  1'b1, 4'b0000, 1'b0, 8'h10, 2'd0};
    vecs[20] = '{1'b0, 2'd3, 4'b1000, D,  1'b0, 4'b1000, 1'b1, 8'h13, 2'd3};
    vecs[21] = '{1'b0, 2'd1, 4'b0010, D,  1'b0, 4'b0000, 1'b1, 8'h13, 2'd3};
    vecs[22] = '{1'b0, 2'd1, 4'b0010, D,  1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};

    // reset state, with a valid request present
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = 2'd0;
    in_valid  = 4'b1111;
    in_data   = D;
    out_ready = 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
    in_last   = 4'b0000;
`endif
    #12;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data",  32'(out_data),  32'd0);
    check("reset_out_chan",  32'(out_chan),  32'd0);
    check("reset_in_ready",  32'(in_ready),  32'd0);
    in_valid = 4'b0000;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;

    for (int r = 0; r < 23; r++) begin
      mode      = vecs[r].md;
      sel       = vecs[r].sl;
      in_valid  = vecs[r].vld;
      in_data   = vecs[r].dat;
      out_ready = vecs[r].ordy;
      #1;
      check($sformatf("row%0d_in_ready", r), 32'(in_ready), 32'(vecs[r].exp_rdy));
      @(posedge clk);
      #1;
      check($sformatf("row%0d_out_valid", r), 32'(out_valid), 32'(vecs[r].exp_ov));
      check($sformatf("row%0d_out_data", r),  32'(out_data),  32'(vecs[r].exp_od));
      check($sformatf("row%0d_out_chan", r),  32'(out_chan),  32'(vecs[r].exp_oc));
    end

    // async reset between edges while a word is held
    mode      = 1'b1;
    in_valid  = 4'b1111;
    in_data   = D;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("pre_reset_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_out_data",  32'(out_data),  32'd0);
    check("async_rst_out_chan",  32'(out_chan),  32'd0);
    check("async_rst_in_ready",  32'(in_ready),  32'd0);
    #1;
    rst_n    = 1'b1;
    in_valid = 4'b0110;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'b0010);
    @(posedge clk);
    #1;
    check("post_rst_out_data", 32'(out_data), 32'h11);
    check("post_rst_out_chan", 32'(out_chan), 32'd1);

`ifdef STREAM_MUX_PKT_LOCK_EN
    // packet lock: ch1 sends 3 words (last on the third) while ch2 waits
    #2;
    rst_n = 1'b0;
    #1;
    rst_n    = 1'b1;
    in_valid = 4'b0110;
    in_last  = 4'b0000;
    @(posedge clk);
    #1;
    check("lock_w0_chan", 32'(out_chan), 32'd1);
    check("lock_w0_last", 32'(out_last), 32'd0);
    @(posedge clk);
    #1;
    check("lock_w1_chan", 32'(out_chan), 32'd1);
    check("lock_w1_last", 32'(out_last), 32'd0);
    in_last = 4'b0010;
    @(posedge clk);
    #1;
    check("lock_w2_chan", 32'(out_chan), 32'd1);
    check("lock_w2_last", 32'(out_last), 32'd1);
    in_last = 4'b0000;
    @(posedge clk);
    #1;
    check("lock_w3_chan", 32'(out_chan), 32'd2);
    check("lock_w3_data", 32'(out_data), 32'h12);
    check("lock_w3_last", 32'(out_last), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_mux_nt1.md
Name: stream_mux_nt1

Overview:
- Parametrised successor to the team's combinational 4:1 mux.
- Selects one of N input channels, each W bits wide, and forwards it through a registered output stage with a valid/ready handshake.
- Two selection modes, chosen at run time: fixed select (driven by `sel`) and round-robin arbitration.
- Sits between N producer streams and one downstream consumer.

Parameters:
- N, 4, number of input channels (N ≥ 2).
- W, 8, data width per channel.
- SW, $clog2(N), select/channel-index width (derived; not overridden).

Ports:
- clk  input  1  clock; rising edge active.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  N  per-channel valid; bit i belongs to channel i.
- in_data  input  N*W  packed channel data; channel i occupies bits [i*W +: W].
- in_ready  output  N  per-channel ready; combinational.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SW  channel index used in fixed mode.
- out_valid  output  1  registered output valid.
- out_data  output  W  registered output data.
- out_chan  output  SW  index of the channel that sourced out_data.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (async on rst_n low): out_valid=0, out_data=0, out_chan=0, rr_ptr=0. All in_ready=0 while rst_n is low.
- Output stage is a single register. load = !out_valid || out_ready.
- Grant, fixed mode (mode=0):
  - grant = one-hot(sel) if in_valid[sel], else none.
  - If sel ≥ N, no grant is issued and in_ready stays all-zero.
- Grant, round-robin mode (mode=1):
  - grant = first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, … mod N.
- in_ready[i] = load && (channel i is the selected candidate).
  - Fixed mode: candidate = sel, so in_ready[sel] follows load even when in_valid[sel]=0.
  - RR mode: candidate = granted channel; in_ready is 0 when no channel is valid.
- Transfer on channel i: in_valid[i] && in_ready[i] at a rising edge. Next cycle: out_data = channel i data, out_chan = i, out_valid = 1.
- When load && no transfer: out_valid goes to 0, and out_data/out_chan hold their values.
- rr_ptr:
  - After a transfer from channel k, rr_ptr = (k+1) mod N; wraps from N-1 to 0.
  - Unchanged when there is no transfer.
  - Also unchanged in fixed mode.
- Latency: one cycle from input handshake to out_valid. Throughput: one word per cycle while out_ready=1.
- Backpressure: when out_valid=1 and out_ready=0, all in_ready=0 and the output register holds.
- Simultaneous out_ready=1 and a new transfer: the register reloads in the same edge (no bubble).
- mode or sel change: takes effect at the next grant evaluation (combinational). A word already held in the output register is unaffected.
- Reset asserted mid-transfer: the held word is discarded, and outputs return to reset values immediately.

Optional Feature:
- Macro: STREAM_MUX_PKT_LOCK_EN.
- When defined:
  - Adds input port in_last [N] and output port out_last [1].
  - out_last is registered alongside out_data and resets to 0.
  - In RR mode, after a transfer from channel k with in_last[k]=0, the grant is locked to channel k. rr_ptr does not advance until a transfer with in_last[k]=1.
  - Lock clears on reset.
  - Fixed mode ignores the lock but still forwards out_last.
- When undefined: no in_last/out_last ports, and arbitration is word-by-word.

Decomposition:
- Package stream_mux_pkg:
  - MODE_FIXED=1'b0, MODE_RR=1'b1.
  - A function for the one-hot-to-index conversion.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req[N], ptr[SW]. Output: gnt[N] one-hot.
  - Purely combinational; rr_ptr and the lock state live in stream_mux_nt1.

Test Plan:
1. N=4, W=8, mode=0, sel=2, in_data ch2=8'hA5, in_valid=4'b0100, out_ready=1 → next cycle out_valid=1, out_data=8'hA5, out_chan=2; in_ready=4'b0100.
2. Round-robin fairness: mode=1, all in_valid=1, data chi=8'h10+i, out_ready=1 for 8 cycles → out_chan sequence 0,1,2,3,0,1,2,3 with no bubbles.
3. Backpressure: after word 8'h11 is captured, hold out_ready=0 for 3 cycles → out_data stays 8'h11, in_ready=0000. Release → the next word appears on the following cycle, and no word is lost or duplicated.
4. Sparse round-robin / wrap: rr_ptr=3, in_valid=4'b0011 → grant ch0, then ch1, then ch0 (pointer wraps 3→0).
5. Async reset: pulse rst_n low mid-stream between clock edges → out_valid=0, out_data=0, out_chan=0 immediately. After release, the first RR grant goes to the lowest valid channel from index 0.
6. Packet lock (STREAM_MUX_PKT_LOCK_EN defined): ch1 sends 3 words with in_last=0,0,1 while ch2 is valid → out_chan=1,1,1, then 2; out_last=1 only on the third word.
